tt_um_mvm: RTL and testbench

- 4x4 signed matrix-vector multiplier packaged as a TinyTapeout user tile.
- Host streams matrix and vector bytes in on ui_in with command codes on uio_in[2:0], starts a sequential computation, then reads result bytes out on uo_out.
- Status flags are driven on uio_out[7:4].
- Sits directly under the TinyTapeout wrapper, which converts its rst_n to this block's active-high rst.

---
 rtl/mvm_pkg.sv | 25 ++
 rtl/mvm_mac.sv | 40 ++++
 rtl/tt_um_mvm.sv | 148 ++++++++++++++
 tb/tb_tt_um_mvm.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared sizes, command encodings and element/result types for
//               the 4x4 signed matrix-vector multiplier tile.
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

    localparam int N  = 4;   // matrix dimension
    localparam int W  = 8;   // element width (signed)
    localparam int RW = 24;  // result width (3 bytes)

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_LOAD_M = 3'b001;
    localparam logic [2:0] CMD_LOAD_V = 3'b010;
    localparam logic [2:0] CMD_START  = 3'b011;
    localparam logic [2:0] CMD_READ   = 3'b100;
    localparam logic [2:0] CMD_CLEAR  = 3'b101;

    typedef logic signed [W-1:0]  elem_t;
    typedef logic signed [RW-1:0] res_t;

endpackage
`default_nettype wire

// File: rtl/mvm_mac.sv
`default_nettype none
// ============================================================================
// Module      : mvm_mac
// Description : Signed W x W multiply with accumulate into an RW-wide register.
//               Ports: clk, rst (sync, active-high), i_clr (zero the
//               accumulator), i_en (add product), i_a/i_b (operands),
//               o_acc (accumulated value).
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_mac
    import mvm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_clr,
    input  logic  i_en,
    input  elem_t i_a,
    input  elem_t i_b,
    output res_t  o_acc
);

    logic signed [2*W-1:0] w_prod;
    res_t                  r_acc;

    assign w_prod = i_a * i_b;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            // Sign-extend the 16-bit product; 4 products need 18 bits, so
            // the 24-bit accumulator can never overflow.
            r_acc <= r_acc + {{(RW-2*W){w_prod[2*W-1]}}, w_prod};
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/tt_um_mvm.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_mvm
// Description : 4x4 signed matrix-vector multiplier TinyTapeout tile.
//               Ports: clk, rst (sync, active-high), ena (tile enable),
//               ui_in (data byte), uio_in[2:0] (command), uo_out (result
//               byte), uio_out[7:4] (status: last/done/busy), uio_oe (F0).
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_mvm
    import mvm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    elem_t       r_mat [0:N*N-1];
    elem_t       r_vec [0:N-1];
    logic [3:0]  r_m_idx;
    logic [1:0]  r_v_idx;
    logic [3:0]  r_cnt;     // MAC sequencer: [3:2]=row, [1:0]=column
    logic [3:0]  r_rd_ptr;
    logic        r_busy;
    logic        r_done;

    logic [2:0]  w_cmd;
    logic        w_start;
    logic        w_step;
    logic        w_unused;
    res_t        w_res [0:N-1];
    logic [1:0]  w_row;
    logic [1:0]  w_byte;
    res_t        w_sel;
    logic [7:0]  w_byte_val;

    assign w_cmd    = uio_in[2:0];
    assign w_unused = &{1'b0, uio_in[7:3]};

    // START is only honoured when idle; a CLEAR in the same cycle as a
    // compute step aborts it, so the step is suppressed.
    assign w_start = ena && !r_busy && (w_cmd == CMD_START);
    assign w_step  = ena &&  r_busy && (w_cmd != CMD_CLEAR);

    // One accumulator per row; only the row addressed by the sequencer adds.
    generate
        for (genvar g = 0; g < N; g++) begin : g_row
            mvm_mac u_mac (
                .clk   (clk),
                .rst   (rst),
                .i_clr (w_start),
                .i_en  (w_step && (r_cnt[3:2] == 2'(g))),
                .i_a   (r_mat[r_cnt]),
                .i_b   (r_vec[r_cnt[1:0]]),
                .o_acc (w_res[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N*N; i++) r_mat[i] <= '0;
            for (int i = 0; i < N; i++)   r_vec[i] <= '0;
            r_m_idx  <= '0;
            r_v_idx  <= '0;
            r_cnt    <= '0;
            r_rd_ptr <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (ena) begin
            if (w_cmd == CMD_CLEAR) begin
                r_m_idx  <= '0;
                r_v_idx  <= '0;
                r_rd_ptr <= '0;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else if (r_busy) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else begin
                case (w_cmd)
                    CMD_LOAD_M: begin
                        r_mat[r_m_idx] <= elem_t'(ui_in);
                        r_m_idx        <= r_m_idx + 4'd1;
                    end
                    CMD_LOAD_V: begin
                        r_vec[r_v_idx] <= elem_t'(ui_in);
                        r_v_idx        <= r_v_idx + 2'd1;
                    end
                    CMD_START: begin
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_rd_ptr <= '0;
                        r_cnt    <= '0;
                    end
                    CMD_READ: begin
                        if (r_done) begin
                            r_rd_ptr <= (r_rd_ptr == 4'd11) ? 4'd0 : r_rd_ptr + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // rd_ptr -> (result index, byte index) without a divider.
    always_comb begin
        w_row  = 2'd0;
        w_byte = 2'd0;
        if (r_rd_ptr < 4'd3) begin
            w_row  = 2'd0;
            w_byte = r_rd_ptr[1:0];
        end else if (r_rd_ptr < 4'd6) begin
            w_row  = 2'd1;
            w_byte = 2'(r_rd_ptr - 4'd3);
        end else if (r_rd_ptr < 4'd9) begin
            w_row  = 2'd2;
            w_byte = 2'(r_rd_ptr - 4'd6);
        end else begin
            w_row  = 2'd3;
            w_byte = 2'(r_rd_ptr - 4'd9);
        end
    end

    always_comb begin
        w_sel = w_res[w_row];
        case (w_byte)
            2'd0:    w_byte_val = w_sel[7:0];
            2'd1:    w_byte_val = w_sel[15:8];
            default: w_byte_val = w_sel[23:16];
        endcase
    end

    assign uo_out  = r_done ? w_byte_val : 8'h00;
    assign uio_out = {1'b0, (r_rd_ptr == 4'd11), r_done, r_busy, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_mvm.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_mvm
// Description : Directed self-checking bench for tt_um_mvm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_mvm;
    import mvm_pkg::*;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_total = 0;
    int n_bad   = 0;

    tt_um_mvm dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one command for one rising edge, then sample 1ns after the edge.
    task automatic cyc(input logic [2:0] cmd, input logic [7:0] d);
        uio_in = {5'b00000, cmd};
        ui_in  = d;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        ui_in  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(CMD_NOP, 8'h00);
    endtask

    // Read all 12 result bytes and compare with the expected results.
    task automatic read_all(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                            input logic [23:0] e2, input logic [23:0] e3);
        logic [23:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_b%0d", tag, i), {24'h0, uo_out},
                32'((e[i/3] >> (8*(i%3))) & 24'hFF));
            cyc(CMD_READ, 8'h00);
        end
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_uo", {24'h0, uo_out}, 32'h00);
        chk("rst_uio_out", {24'h0, uio_out}, 32'h00);
        chk("rst_uio_oe", {24'h0, uio_oe}, 32'hF0);
        rst = 1'b0;

        // Identity matrix, V = 1,2,3,4
        for (int i = 0; i < 16; i++) cyc(CMD_LOAD_M, ((i/4) == (i%4)) ? 8'h01 : 8'h00);
        for (int i = 0; i < 4; i++)  cyc(CMD_LOAD_V, 8'(i + 1));
        cyc(CMD_START, 8'h00);
        chk("start_busy", {31'h0, uio_out[4]}, 32'h1);
        chk("start_done", {31'h0, uio_out[5]}, 32'h0);
        for (int i = 1; i <= 15; i++) begin
            if (i == 3) cyc(CMD_LOAD_M, 8'h55);
            else        cyc(CMD_NOP, 8'h00);
        end
        chk("k15_busy", {31'h0, uio_out[4]}, 32'h1);
        chk("k15_done", {31'h0, uio_out[5]}, 32'h0);
        cyc(CMD_NOP, 8'h00);
        chk("k16_busy", {31'h0, uio_out[4]}, 32'h0);
        chk("k16_done", {31'h0, uio_out[5]}, 32'h1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("id_b%0d", i), {24'h0, uo_out},
                ((i % 3) == 0) ? 32'(i/3 + 1) : 32'h0);
            chk($sformatf("id_last%0d", i), {31'h0, uio_out[6]}, (i == 11) ? 32'h1 : 32'h0);
            cyc(CMD_READ, 8'h00);
        end
        chk("id_wrap", {24'h0, uo_out}, 32'h01);
        // Recompute: the LOAD_M issued while busy must not have touched M[0]
        cyc(CMD_START, 8'h00);
        idle(16);
        read_all("id2", 24'h000001, 24'h000002, 24'h000003, 24'h000004);

        // All 0x80 matrix and vector
        cyc(CMD_CLEAR, 8'h00);
        for (int i = 0; i < 16; i++) cyc(CMD_LOAD_M, 8'h80);
        for (int i = 0; i < 4; i++)  cyc(CMD_LOAD_V, 8'h80);
        cyc(CMD_START, 8'h00);
        idle(16);
        read_all("nn", 24'h010000, 24'h010000, 24'h010000, 24'h010000);

        // Vector all 0x7F: -128*127*4 = -65024
        cyc(CMD_CLEAR, 8'h00);
        for (int i = 0; i < 4; i++) cyc(CMD_LOAD_V, 8'h7F);
        cyc(CMD_START, 8'h00);
        idle(16);
        read_all("np", 24'hFF0200, 24'hFF0200, 24'hFF0200, 24'hFF0200);

        // CLEAR at cycle 5 of a compute, then recompute with V = 1,2,3,4
        cyc(CMD_CLEAR, 8'h00);
        for (int i = 0; i < 4; i++) cyc(CMD_LOAD_V, 8'(i + 1));
        cyc(CMD_START, 8'h00);
        idle(4);
        cyc(CMD_CLEAR, 8'h00);
        chk("clr_busy", {31'h0, uio_out[4]}, 32'h0);
        chk("clr_done", {31'h0, uio_out[5]}, 32'h0);
        chk("clr_uo", {24'h0, uo_out}, 32'h00);
        idle(2);
        chk("clr_stay", {31'h0, uio_out[4]}, 32'h0);
        cyc(CMD_START, 8'h00);
        idle(16);
        read_all("rc", 24'hFFFB00, 24'hFFFB00, 24'hFFFB00, 24'hFFFB00);

        // ena = 0: LOAD_M, READ and START ignored
        ena = 1'b0;
        cyc(CMD_LOAD_M, 8'h11);
        cyc(CMD_READ, 8'h00);
        cyc(CMD_START, 8'h00);
        chk("ena_busy", {31'h0, uio_out[4]}, 32'h0);
        chk("ena_done", {31'h0, uio_out[5]}, 32'h1);
        ena = 1'b1;
        read_all("ena_rd", 24'hFFFB00, 24'hFFFB00, 24'hFFFB00, 24'hFFFB00);
        cyc(CMD_START, 8'h00);
        idle(16);
        read_all("ena_rc", 24'hFFFB00, 24'hFFFB00, 24'hFFFB00, 24'hFFFB00);

        // Reset in the middle of a compute
        cyc(CMD_START, 8'h00);
        idle(5);
        rst = 1'b1;
        cyc(CMD_NOP, 8'h00);
        rst = 1'b0;
        chk("mrst_uo", {24'h0, uo_out}, 32'h00);
        chk("mrst_uio_out", {24'h0, uio_out}, 32'h00);
        chk("mrst_uio_oe", {24'h0, uio_oe}, 32'hF0);
        cyc(CMD_START, 8'h00);
        idle(16);
        chk("mrst_done", {31'h0, uio_out[5]}, 32'h1);
        read_all("mrst", 24'h0, 24'h0, 24'h0, 24'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
